temp_sensor_filter: RTL and testbench
=====================================

Name: temp_sensor_filter

Overview:
- Upstream conditioning stage for the smart-home controller.
- Accepts raw 5-bit temperature samples from the sensor interface and produces the filtered, registered `temperature` bus that the controller consumes.
- Filtering is a 4-sample moving average with single-sample outlier rejection.
- Flags the reading as not valid during warm-up and when the sensor goes silent (stale).

Parameters:
- WIDTH, 5, sample and output width in bits.
- WINDOW_LOG2, 2, log2 of averaging window (window = 4 samples).
- MAX_STEP, 8, largest accepted |sample − temperature| in RUN without outlier handling.
- TIMEOUT, 1000, clock cycles without sample_valid before stale asserts.
- DEFAULT_TEMP, 20, reset value of buffer entries and output (mid comfort band, controller idle).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- sample_in  input  WIDTH  raw sensor sample, unsigned.
- sample_valid  input  1  sample_in valid this cycle; one-cycle qualifier, no backpressure.
- temperature  output  WIDTH  filtered temperature to controller, registered.
- temp_valid  output  1  temperature trustworthy (window full, not stale).
- stale  output  1  no sample_valid for TIMEOUT cycles.
- outlier  output  1  one-cycle pulse when a sample is rejected.

Behaviour:
- Reset (rst=0, async):
  - All 2^WINDOW_LOG2 buffer entries = DEFAULT_TEMP; sum = DEFAULT_TEMP<<WINDOW_LOG2.
  - temperature=DEFAULT_TEMP, temp_valid=0, stale=0, outlier=0.
  - wr_ptr=0, fill count=0, idle counter=0, FSM=WARMUP.
- Datapath:
  - sum width = WIDTH+WINDOW_LOG2 (7 bits).
  - On accepted sample: sum ← sum − buf[wr_ptr] + sample_in; buf[wr_ptr] ← sample_in; wr_ptr increments and wraps modulo window.
  - temperature ← (new_sum + 2^(WINDOW_LOG2−1)) >> WINDOW_LOG2, i.e. round-half-up.
  - The result cannot exceed 2^WIDTH−1, so no saturation is needed.
- Latency: a sample accepted at edge N is reflected in temperature immediately after edge N (1 cycle). temperature holds in all other cycles.
- FSM:
  - WARMUP:
    - Every valid sample is accepted (no outlier check); fill count increments.
    - On the 4th accepted sample → RUN, and temp_valid=1 from the same edge.
  - RUN:
    - Sample with |sample_in − temperature| ≤ MAX_STEP: accepted.
    - Sample with difference > MAX_STEP, when the previous valid sample was not rejected: dropped, outlier=1 for one cycle, temperature unchanged.
    - A second consecutive out-of-range sample is accepted (genuine step). Any accepted sample clears the reject flag.
  - STALE:
    - stale=1, temp_valid=0, temperature held.
    - The next valid sample is accepted without outlier check → RUN; stale=0 and temp_valid=1 on that edge. No re-warm-up.
- Idle counter:
  - Clears on every sample_valid, including rejected outliers (sensor alive).
  - Otherwise increments, saturating at TIMEOUT.
  - Reaching TIMEOUT in WARMUP or RUN → STALE on the next edge.
  - In WARMUP, stale asserts but the FSM stays counting fill, and leaves via the 4th sample to RUN.
- Simultaneous events: sample_valid in the cycle the counter would reach TIMEOUT → the sample wins; counter clears and stale stays 0.
- Reset mid-operation: immediately returns all state to reset values regardless of FSM state.
- sample_in is ignored when sample_valid=0.

Test Plan:
- Reset: hold rst=0 with sample_valid toggling → temperature=20, temp_valid=0, stale=0, outlier=0 throughout.
- Warm-up: four consecutive samples of 16 → temperature 19, 18, 17, 16 after successive edges; temp_valid rises with the 4th.
- Accepted step: steady 16, sample 24 (diff 8 = MAX_STEP) → accepted, temperature=18, outlier=0.
- Outlier: steady 16, sample 31 → outlier pulse, temperature stays 16. Next sample 31 → accepted, temperature=20 ((79+2)>>2).
- Timeout: steady 16 in RUN, then no sample_valid for 1000 cycles → stale=1 and temp_valid=0, temperature=16. Sample 17 → stale=0, temp_valid=1, temperature=16 ((65+2)>>2).
- Reset mid-run: in RUN with temperature=16, pulse rst=0 between clock edges → outputs return to 20/0/0 asynchronously. Subsequent samples show WARMUP behaviour again.

Source files
------------

// File: rtl/temp_sensor_filter.sv
// Input conditioning for the smart-home controller: a 4-sample moving average with
// single-sample outlier rejection, plus warm-up and stale-sensor qualification.
module temp_sensor_filter #(
    parameter int WIDTH        = 5,
    parameter int WINDOW_LOG2  = 2,
    parameter int MAX_STEP     = 8,
    parameter int TIMEOUT      = 1000,
    parameter int DEFAULT_TEMP = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid,
    output logic [WIDTH-1:0] temperature,
    output logic             temp_valid,
    output logic             stale,
    output logic             outlier
);

    localparam int WINDOW = 1 << WINDOW_LOG2;
    localparam int SUM_W  = WIDTH + WINDOW_LOG2;
    localparam int IDLE_W = $clog2(TIMEOUT + 1);

    localparam logic [WIDTH-1:0]       DEF_TEMP   = WIDTH'(DEFAULT_TEMP);
    localparam logic [SUM_W-1:0]       SUM_RESET  = SUM_W'(DEFAULT_TEMP << WINDOW_LOG2);
    localparam logic [SUM_W-1:0]       ROUND_HALF = SUM_W'(1 << (WINDOW_LOG2 - 1));
    localparam logic [WIDTH:0]         MAX_STEP_C = (WIDTH + 1)'(MAX_STEP);
    localparam logic [IDLE_W-1:0]      TIMEOUT_C  = IDLE_W'(TIMEOUT);
    localparam logic [WINDOW_LOG2-1:0] FILL_LAST  = WINDOW_LOG2'(WINDOW - 1);

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1,
        STALE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       sampleBuf_q [WINDOW];
    logic [SUM_W-1:0]       sum_q;
    logic [WINDOW_LOG2-1:0] wrPtr_q;
    logic [WINDOW_LOG2-1:0] fill_q;
    logic [IDLE_W-1:0]      idle_q, idle_d;
    logic                   reject_q;
    logic                   outlier_q;
    logic [WIDTH-1:0]       temp_q;

    logic [WIDTH-1:0] diff;
    logic             inRange;
    logic             accept;
    logic             reject;
    logic [SUM_W-1:0] sumNext;
    logic [SUM_W-1:0] rounded;
    logic [WIDTH-1:0] tempNext;

    // A second consecutive out-of-range sample is taken as a genuine step, hence reject_q.
    always_comb begin
        diff    = (sample_in >= temp_q) ? (sample_in - temp_q) : (temp_q - sample_in);
        inRange = ({1'b0, diff} <= MAX_STEP_C);
        accept  = 1'b0;
        reject  = 1'b0;
        if (sample_valid) begin
            if (state_q == RUN) begin
                if (inRange || reject_q) begin
                    accept = 1'b1;
                end else begin
                    reject = 1'b1;
                end
            end else begin
                accept = 1'b1;
            end
        end
    end

    always_comb begin
        sumNext  = sum_q - SUM_W'(sampleBuf_q[wrPtr_q]) + SUM_W'(sample_in);
        rounded  = sumNext + ROUND_HALF;
        tempNext = WIDTH'(rounded >> WINDOW_LOG2);
    end

    // Any sample, even a rejected one, proves the sensor is alive.
    always_comb begin
        if (sample_valid) begin
            idle_d = '0;
        end else if (idle_q == TIMEOUT_C) begin
            idle_d = idle_q;
        end else begin
            idle_d = idle_q + IDLE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WARMUP: begin
                if (accept && (fill_q == FILL_LAST)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (idle_d == TIMEOUT_C) begin
                    state_d = STALE;
                end
            end
            STALE: begin
                if (accept) begin
                    state_d = RUN;
                end
            end
            default: state_d = WARMUP;
        endcase
    end

    // Warm-up never leaves WARMUP on timeout, so stale is flagged from the idle count there.
    always_comb begin
        temperature = temp_q;
        outlier     = outlier_q;
        temp_valid  = (state_q == RUN);
        stale       = (state_q == STALE) || ((state_q == WARMUP) && (idle_q == TIMEOUT_C));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < WINDOW; i++) begin
                sampleBuf_q[i] <= DEF_TEMP;
            end
            sum_q     <= SUM_RESET;
            wrPtr_q   <= '0;
            fill_q    <= '0;
            idle_q    <= '0;
            reject_q  <= 1'b0;
            outlier_q <= 1'b0;
            temp_q    <= DEF_TEMP;
        end else begin
            idle_q    <= idle_d;
            outlier_q <= reject;
            if (sample_valid) begin
                reject_q <= reject;
            end
            if (accept) begin
                sampleBuf_q[wrPtr_q] <= sample_in;
                sum_q                <= sumNext;
                wrPtr_q              <= wrPtr_q + WINDOW_LOG2'(1);
                temp_q               <= tempNext;
                if (state_q == WARMUP) begin
                    fill_q <= fill_q + WINDOW_LOG2'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_temp_sensor_filter.sv
// Scoreboard bench for temp_sensor_filter: a reference model queues the expected outputs
// for each driven sample and every scenario task pops and compares them after the edge.
module tb_temp_sensor_filter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] sample_in;
    logic       sample_valid;
    logic [4:0] temperature;
    logic       temp_valid;
    logic       stale;
    logic       outlier;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0] temp;
        logic       tv;
        logic       st;
        logic       ol;
    } exp_t;

    exp_t sb[$];

    logic [4:0] mBuf [4];
    int         mPtr;
    int         mFill;
    int         mMode;
    bit         mRej;
    logic [4:0] mTemp;

    temp_sensor_filter dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .temperature  (temperature),
        .temp_valid   (temp_valid),
        .stale        (stale),
        .outlier      (outlier)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mBuf[i] = 5'd20;
        mPtr  = 0;
        mFill = 0;
        mMode = 0;
        mRej  = 1'b0;
        mTemp = 5'd20;
        sb.delete();
    endtask

    // Model: mMode 0 = warm-up, 1 = run, 2 = stale; the average is recomputed from the whole window.
    task automatic sendSample(input logic [4:0] v);
        exp_t e;
        int   d;
        int   s;
        @(negedge clk);
        sample_in    = v;
        sample_valid = 1'b1;
        d = int'(v) - int'(mTemp);
        if (d < 0) d = -d;
        e.ol = 1'b0;
        if (mMode == 1 && d > 8 && !mRej) begin
            e.ol = 1'b1;
            mRej = 1'b1;
        end else begin
            mRej       = 1'b0;
            mBuf[mPtr] = v;
            mPtr       = (mPtr + 1) % 4;
            s = 0;
            for (int i = 0; i < 4; i++) s += int'(mBuf[i]);
            mTemp = 5'((s + 2) / 4);
            if (mMode == 0) begin
                mFill++;
                if (mFill == 4) mMode = 1;
            end else begin
                mMode = 1;
            end
        end
        e.temp = mTemp;
        e.tv   = (mMode == 1);
        e.st   = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        sample_in    = 5'($urandom);
    endtask

    task automatic popExp(output exp_t e);
        e = sb.pop_front();
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        rst = 1'b1;
        modelReset();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            sample_valid = (i % 2 == 0);
            sample_in    = 5'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if ({temperature, temp_valid, stale, outlier} !== {5'd20, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL reset_hold got %0d/%0b/%0b/%0b expected 20/0/0/0",
                         temperature, temp_valid, stale, outlier);
            end
        end
        @(negedge clk);
        sample_valid = 1'b0;
        rst = 1'b1;
        modelReset();
    endtask

    task automatic test_warmup();
        logic [4:0] expTemp [4];
        exp_t e;
        expTemp = '{5'd19, 5'd18, 5'd17, 5'd16};
        pulseReset();
        for (int i = 0; i < 4; i++) begin
            sendSample(5'd16);
            popExp(e);
            checks++;
            if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}
                || temperature !== expTemp[i] || temp_valid !== (i == 3)) begin
                errors++;
                $display("[TB] FAIL warmup_%0d got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         i, temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
            end
        end
    endtask

    task automatic test_step();
        logic [4:0] stim [5];
        exp_t e;
        stim = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd24};
        for (int i = 0; i < 5; i++) begin
            sendSample(stim[i]);
            popExp(e);
            checks++;
            if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}) begin
                errors++;
                $display("[TB] FAIL step_%0d got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         i, temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
            end
        end
        checks++;
        if (temperature !== 5'd18 || outlier !== 1'b0) begin
            errors++;
            $display("[TB] FAIL step_max got temp=%0d outlier=%0b expected temp=18 outlier=0",
                     temperature, outlier);
        end
    endtask

    task automatic test_outlier();
        logic [4:0] stim [6];
        exp_t e;
        stim = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd31, 5'd31};
        for (int i = 0; i < 6; i++) begin
            sendSample(stim[i]);
            popExp(e);
            checks++;
            if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}) begin
                errors++;
                $display("[TB] FAIL outlier_%0d got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         i, temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
            end
        end
        checks++;
        if (temperature !== 5'd20) begin
            errors++;
            $display("[TB] FAIL outlier_step got temp=%0d expected temp=20", temperature);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] stim [7];
        exp_t e;
        logic [4:0] held;
        stim = '{5'd16, 5'd16, 5'd16, 5'd16, 5'd31, 5'd17, 5'd31};
        for (int i = 0; i < 7; i++) begin
            sendSample(stim[i]);
            popExp(e);
            checks++;
            if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}) begin
                errors++;
                $display("[TB] FAIL b2b_%0d got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         i, temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
            end
        end
        held = mTemp;
        @(posedge clk);
        #1;
        checks++;
        if (outlier !== 1'b0 || temperature !== held) begin
            errors++;
            $display("[TB] FAIL outlier_pulse got outlier=%0b temp=%0d expected outlier=0 temp=%0d",
                     outlier, temperature, held);
        end
    endtask

    task automatic test_timeout();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sendSample(5'd16);
            popExp(e);
        end
        repeat (995) @(posedge clk);
        #1;
        checks++;
        if (stale !== 1'b0 || temp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL timeout_early got stale=%0b valid=%0b expected stale=0 valid=1",
                     stale, temp_valid);
        end
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if ({temperature, temp_valid, stale, outlier} !== {5'd16, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL timeout_stale got %0d/%0b/%0b/%0b expected 16/0/1/0",
                     temperature, temp_valid, stale, outlier);
        end
        mMode = 2;
        sendSample(5'd17);
        popExp(e);
        checks++;
        if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}
            || temperature !== 5'd16) begin
            errors++;
            $display("[TB] FAIL stale_recover got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                     temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
        end
    endtask

    task automatic test_simultaneous();
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            sendSample(5'd16);
            popExp(e);
        end
        repeat (999) @(posedge clk);
        sendSample(5'd16);
        popExp(e);
        checks++;
        if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}) begin
            errors++;
            $display("[TB] FAIL sample_wins got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                     temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (stale !== 1'b0 || temp_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sample_wins_after got stale=%0b valid=%0b expected stale=0 valid=1",
                     stale, temp_valid);
        end
    endtask

    task automatic test_warmup_stale();
        exp_t e;
        pulseReset();
        repeat (1005) @(posedge clk);
        #1;
        checks++;
        if ({temperature, temp_valid, stale, outlier} !== {5'd20, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL warmup_stale got %0d/%0b/%0b/%0b expected 20/0/1/0",
                     temperature, temp_valid, stale, outlier);
        end
        for (int i = 0; i < 4; i++) begin
            sendSample(5'd16);
            popExp(e);
            checks++;
            if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}) begin
                errors++;
                $display("[TB] FAIL warmup_stale_fill_%0d got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         i, temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
            end
        end
    endtask

    task automatic test_reset_midrun();
        logic [4:0] stim [2];
        exp_t e;
        stim = '{5'd16, 5'd31};
        for (int i = 0; i < 4; i++) begin
            sendSample(5'd16);
            popExp(e);
        end
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        checks++;
        if ({temperature, temp_valid, stale, outlier} !== {5'd20, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL async_reset got %0d/%0b/%0b/%0b expected 20/0/0/0",
                     temperature, temp_valid, stale, outlier);
        end
        @(negedge clk);
        rst = 1'b1;
        modelReset();
        for (int i = 0; i < 2; i++) begin
            sendSample(stim[i]);
            popExp(e);
            checks++;
            if ({temperature, temp_valid, stale, outlier} !== {e.temp, e.tv, e.st, e.ol}) begin
                errors++;
                $display("[TB] FAIL rewarm_%0d got %0d/%0b/%0b/%0b expected %0d/%0b/%0b/%0b",
                         i, temperature, temp_valid, stale, outlier, e.temp, e.tv, e.st, e.ol);
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        sample_valid = 1'b0;
        sample_in    = 5'd0;
        modelReset();
        test_reset();
        test_warmup();
        test_step();
        test_outlier();
        test_back_to_back();
        test_timeout();
        test_simultaneous();
        test_warmup_stale();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
